// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM encoding and
// the default operand width.
package serial_addsub_pkg;

   localparam int WIDTH_DEFAULT = 8;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

endpackage

// File: rtl/fulladder.sv
// One-bit full adder used as the single bit-slice of serial_addsub.
module fulladder (
   output logic s,
   output logic c,
   input  logic x,
   input  logic y,
   input  logic z
);

   assign s = x ^ y ^ z;
   assign c = (x & y) | (z & (x ^ y));

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor. One full adder processes one bit per clock,
// LSB first; the sum bit is shifted into the result MSB so that after WIDTH
// RUN cycles the result register holds the full sum/difference.
// Subtraction is a + ~b + 1 (carry flop preloaded with 1).
//
// Handshake: start is sampled only in IDLE. busy is high in RUN and DONE,
// done is a one-cycle pulse in DONE; result/cout/overflow stay stable from
// done until the next accepted start.
//
// Optional feature: define SERIAL_ADDSUB_OVF_EN to build the signed-overflow
// flag; without it the overflow port is tied to 0.
module serial_addsub
   import serial_addsub_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             overflow
);

   // Counter must be able to represent WIDTH itself without wrapping.
   localparam int            CW       = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   state_t            state;
   logic [WIDTH-1:0]  a_q;
   logic [WIDTH-1:0]  b_q;
   logic              carry_q;
   logic [CW-1:0]     cnt;
   logic              sum_bit;
   logic              carry_nxt;

   fulladder u_fa (
      .s (sum_bit),
      .c (carry_nxt),
      .x (a_q[0]),
      .y (b_q[0]),
      .z (carry_q)
   );

   // Control FSM plus datapath registers; all outputs registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         result  <= '0;
         cout    <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         cnt     <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  a_q     <= a;
                  b_q     <= sub ? ~b : b;
                  carry_q <= sub;
                  cnt     <= '0;
                  busy    <= 1'b1;
                  state   <= RUN;
               end
            end
            RUN: begin
               result  <= {sum_bit, result[WIDTH-1:1]};
               a_q     <= a_q >> 1;
               b_q     <= b_q >> 1;
               carry_q <= carry_nxt;
               cnt     <= cnt + CW'(1);
               if (cnt == LAST_BIT) begin
                  cout  <= carry_nxt;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef SERIAL_ADDSUB_OVF_EN
   logic ovf_q;

   // On the MSB slice carry_q is the carry into the MSB and carry_nxt the
   // carry out of it; their XOR is signed overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
      end else if (state == RUN && cnt == LAST_BIT) begin
         ovf_q <= carry_q ^ carry_nxt;
      end
   end

   assign overflow = ovf_q;
`else
   assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub (WIDTH=8): vector table plus hand-written
// sequences for start re-pulse, mid-RUN reset and back-to-back throughput.
module tb_serial_addsub;

   localparam int W = 8;
`ifdef SERIAL_ADDSUB_OVF_EN
   localparam bit OVF_ON = 1'b1;
`else
   localparam bit OVF_ON = 1'b0;
`endif

   typedef struct {
      logic         sub;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] exp_res;
      logic         exp_cout;
      logic         exp_ovf;
   } vec_t;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic         sub;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         cout;
   logic         overflow;

   int             n_checks = 0;
   int             n_pass   = 0;
   int             cyc      = 0;
   logic [W+1:0]   exp_q[$];   // {overflow, cout, result}
   vec_t           vecs[12];

   serial_addsub #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .sub      (sub),
      .a        (a),
      .b        (b),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .cout     (cout),
      .overflow (overflow)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   function automatic logic [W+1:0] ref_model(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
      logic [W-1:0] yy;
      logic [W:0]   sum;
      logic         ov;
      yy  = s ? ~y : y;
      sum = {1'b0, x} + {1'b0, yy} + (W+1)'(s);
      ov  = (x[W-1] == yy[W-1]) && (sum[W-1] != x[W-1]);
      return {ov & OVF_ON, sum};
   endfunction

   // ---------------- drivers ----------------
   task automatic issue(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
      @(negedge clk);
      start = 1'b1;
      sub   = s;
      a     = x;
      b     = y;
      @(posedge clk);
      #1;
      start = 1'b0;
      sub   = 1'($urandom_range(0, 1));
      a     = W'($urandom_range(0, 255));
      b     = W'($urandom_range(0, 255));
   endtask

   // Count negedges after the sampling edge until done is seen (bounded).
   task automatic wait_done(output int lat);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!done && lat < 40);
   endtask

   task automatic score(input string tag);
      logic [W+1:0] e;
      if (exp_q.size() == 0) begin
         check({tag, "_queue"}, 32'd0, 32'd1);
      end else begin
         e = exp_q.pop_front();
         check({tag, "_result"},   result,   e[W-1:0]);
         check({tag, "_cout"},     cout,     e[W]);
         check({tag, "_overflow"}, overflow, e[W+1]);
      end
   endtask

   // ---------------- main test ----------------
   initial begin
      int           lat;
      int           n_done;
      int           t_acc;
      int           t_prev;
      logic [2:0]   kk;
      logic [W-1:0] xa;
      logic [W-1:0] xb;

      rst_n = 1'b1;
      start = 1'b0;
      sub   = 1'b0;
      a     = '0;
      b     = '0;
      t_prev = 0;
      #1 rst_n = 1'b0;

      //            sub   a      b      res    cout  ovf
      vecs[0]  = '{1'b0, 8'h05, 8'h03, 8'h08, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
      vecs[2]  = '{1'b1, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0};
      vecs[3]  = '{1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
      vecs[4]  = '{1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1};
      vecs[5]  = '{1'b1, 8'h07, 8'h05, 8'h02, 1'b1, 1'b0};
      vecs[6]  = '{1'b1, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0};
      vecs[7]  = '{1'b0, 8'h10, 8'h20, 8'h30, 1'b0, 1'b0};
      vecs[8]  = '{1'b0, 8'hAA, 8'h55, 8'hFF, 1'b0, 1'b0};
      vecs[9]  = '{1'b1, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0};
      vecs[10] = '{1'b1, 8'h7F, 8'hFF, 8'h80, 1'b0, 1'b1};
      vecs[11] = '{1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1};

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_busy",     busy,     1'b0);
      check("rst_done",     done,     1'b0);
      check("rst_result",   result,   '0);
      check("rst_cout",     cout,     1'b0);
      check("rst_overflow", overflow, 1'b0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Table-driven vectors
      for (int i = 0; i < 12; i++) begin
         exp_q.push_back({vecs[i].exp_ovf & OVF_ON, vecs[i].exp_cout, vecs[i].exp_res});
         issue(vecs[i].sub, vecs[i].a, vecs[i].b);
         wait_done(lat);
         check($sformatf("vec%0d_latency", i), lat, W + 1);
         score($sformatf("vec%0d", i));
         @(negedge clk);
         check($sformatf("vec%0d_done_pulse", i), done, 1'b0);
         check($sformatf("vec%0d_idle", i), busy, 1'b0);
         check($sformatf("vec%0d_hold", i), result, vecs[i].exp_res);
      end

      // Reset in the middle of RUN: outputs clear at once, no done follows
      issue(1'b0, 8'h0F, 8'h00);
      repeat (4) @(negedge clk);
      check("midrst_busy_before", busy, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_busy",     busy,     1'b0);
      check("midrst_done",     done,     1'b0);
      check("midrst_result",   result,   '0);
      check("midrst_cout",     cout,     1'b0);
      check("midrst_overflow", overflow, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      n_done = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (done) n_done++;
      end
      check("midrst_no_done", n_done, 0);
      exp_q.push_back(ref_model(1'b0, 8'h10, 8'h20));
      issue(1'b0, 8'h10, 8'h20);
      wait_done(lat);
      check("postrst_latency", lat, W + 1);
      check("postrst_result_const", result, 8'h30);
      score("postrst");

      // Start re-pulsed during RUN with other operands: ignored
      exp_q.push_back({1'b0, 1'b0, 8'h08});
      issue(1'b0, 8'h05, 8'h03);
      repeat (2) @(negedge clk);
      start = 1'b1;
      sub   = 1'b1;
      a     = 8'hFF;
      b     = 8'hFF;
      repeat (3) @(negedge clk);
      start = 1'b0;
      n_done = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done) begin
            n_done++;
            score("repulse");
         end
      end
      check("repulse_single_done", n_done, 1);
      check("repulse_idle", busy, 1'b0);

      // Back-to-back starts across sub / operand-MSB corners
      for (int k = 0; k < 8; k++) begin
         kk = 3'(k);
         @(negedge clk);
         check($sformatf("b2b%0d_idle", k), busy, 1'b0);
         xa = {kk[1], 7'($urandom_range(0, 127))};
         xb = {kk[0], 7'($urandom_range(0, 127))};
         sub   = kk[2];
         a     = xa;
         b     = xb;
         start = 1'b1;
         exp_q.push_back(ref_model(kk[2], xa, xb));
         @(posedge clk);
         #1;
         t_acc = cyc;
         check($sformatf("b2b%0d_accept", k), busy, 1'b1);
         sub = 1'($urandom_range(0, 1));
         a   = W'($urandom_range(0, 255));
         b   = W'($urandom_range(0, 255));
         if (k > 0) check($sformatf("b2b%0d_period", k), t_acc - t_prev, W + 2);
         t_prev = t_acc;
         wait_done(lat);
         check($sformatf("b2b%0d_latency", k), lat, W + 1);
         score($sformatf("b2b%0d", k));
      end
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("final_idle", busy, 1'b0);
      check("scoreboard_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
